// File: rtl/hazard_pkg.sv
// Shared record layout, hazard kind encodings and control FSM states for the hazard log.
// Combinational helpers only: zero latency, no flow control.
// Backpressure: not applicable.
package hazard_pkg;

    localparam int PROD_W = 3;
    localparam int CONS_W = 3;
    localparam int KIND_W = 2;
    localparam int REC_W  = 8;

    localparam int PROD_MSB = 7;
    localparam int PROD_LSB = 5;
    localparam int CONS_MSB = 4;
    localparam int CONS_LSB = 2;
    localparam int KIND_MSB = 1;
    localparam int KIND_LSB = 0;

    localparam logic [KIND_W-1:0] KIND_NONE     = 2'b00;
    localparam logic [KIND_W-1:0] KIND_RAW_EX   = 2'b01;
    localparam logic [KIND_W-1:0] KIND_RAW_MEM  = 2'b10;
    localparam logic [KIND_W-1:0] KIND_LOAD_USE = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FROZEN = 2'b01,
        ST_FLUSH  = 2'b10
    } state_e;

    typedef logic [REC_W-1:0] rec_t;

    function automatic rec_t pack_rec(input logic [PROD_W-1:0] prod,
                                      input logic [CONS_W-1:0] cons,
                                      input logic [KIND_W-1:0] kind);
        rec_t r;
        r                    = '0;
        r[PROD_MSB:PROD_LSB] = prod;
        r[CONS_MSB:CONS_LSB] = cons;
        r[KIND_MSB:KIND_LSB] = kind;
        return r;
    endfunction

endpackage

// File: rtl/hazard_log_ctrl_if.sv
// Event input and record readout bundle between the HDU/display side and the hazard log.
// Wires only: zero latency.
// Backpressure: rd_ready from the display stalls the readout head.
interface hazard_log_ctrl_if;

    logic                            ev_valid;
    logic [hazard_pkg::PROD_W-1:0]   ev_prod;
    logic [hazard_pkg::CONS_W-1:0]   ev_cons;
    logic [hazard_pkg::KIND_W-1:0]   ev_kind;
    logic                            rd_valid;
    logic                            rd_ready;
    logic [hazard_pkg::REC_W-1:0]    rd_data;

    modport master (
        output ev_valid, ev_prod, ev_cons, ev_kind, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  ev_valid, ev_prod, ev_cons, ev_kind, rd_ready,
        output rd_valid, rd_data
    );

endinterface

// File: rtl/hazlog_fifo.sv
// Circular record store with pointers, occupancy and an oldest-first flattened snapshot.
// Latency: a pushed record appears on rdata/hazard_mem one cycle after the push edge.
// Backpressure: none internally; the caller must never push when full without popping.
module hazlog_fifo
    import hazard_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  rec_t                     wdata,
    output rec_t                     rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH*REC_W-1:0]   hazard_mem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rec_t                   mem_q [DEPTH];
    rec_t                   mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DEPTH*REC_W-1:0] flat_d, flat_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Snapshot is built from next-state values so it is registered alongside count.
    always_comb begin
        flat_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_d) begin
                flat_d[REC_W*i +: REC_W] = mem_d[rd_ptr_d + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            flat_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            flat_q   <= flat_d;
        end
    end

    assign rdata      = mem_q[rd_ptr_q];
    assign count      = cnt_q;
    assign hazard_mem = flat_q;

endmodule

// File: rtl/hazard_log_ctrl.sv
// RAW hazard event logger: RUN/FROZEN/FLUSH control, accept/dedup, saturating drop counter.
// Latency: accepted event visible on rd_data/hazard_mem/count one cycle later, no bypass.
// Backpressure: rd_ready stalls the head; a full log with no pop drops events (drop_cnt).
// Optional: HAZLOG_DEDUP_EN suppresses an event equal to the last record pushed.
module hazard_log_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    hazard_log_ctrl_if.slave         hif,
    input  logic                     freeze,
    input  logic                     flush,
    output logic [DEPTH*REC_W-1:0]   hazard_mem,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [1:0]               state
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e state_q, state_d;
    logic   clr, pop, accept, dup, full, push, drop;
    rec_t   rec;

    assign rec = pack_rec(hif.ev_prod, hif.ev_cons, hif.ev_kind);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush)       state_d = ST_FLUSH;
                else if (freeze) state_d = ST_FROZEN;
            end
            ST_FROZEN: begin
                if (flush)        state_d = ST_FLUSH;
                else if (!freeze) state_d = ST_RUN;
            end
            default: begin
                state_d = freeze ? ST_FROZEN : ST_RUN;
            end
        endcase
    end

    always_comb begin
        clr          = flush && (state_q != ST_FLUSH);
        hif.rd_valid = (count != '0) && (state_q != ST_FLUSH);
        pop          = hif.rd_valid && hif.rd_ready;
        accept       = (state_q == ST_RUN) && hif.ev_valid &&
                       (hif.ev_kind != KIND_NONE) && (hif.ev_prod != '0);
    end

    assign full = (count == CW'(DEPTH));
    assign push = accept && !dup && (!full || pop);
    assign drop = accept && !dup && full && !pop;

`ifdef HAZLOG_DEDUP_EN
    rec_t last_q;
    logic last_vld_q;

    assign dup = last_vld_q && (last_q == rec);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (clr) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= rec;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    hazlog_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .push       (push),
        .pop        (pop),
        .wdata      (rec),
        .rdata      (hif.rd_data),
        .count      (count),
        .hazard_mem (hazard_mem)
    );

    assign state = state_q;

endmodule

// File: tb/tb_hazard_log_ctrl.sv
// Bench for hazard_log_ctrl: queue-based reference model compared every cycle, plus directed literal checks.
module tb_hazard_log_ctrl;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
`ifdef HAZLOG_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [63:0] hazard_mem;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    hazard_log_ctrl_if hif ();

    hazard_log_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .hif        (hif),
        .freeze     (freeze),
        .flush      (flush),
        .hazard_mem (hazard_mem),
        .count      (count),
        .drop_cnt   (drop_cnt),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the log is an oldest-first queue of records.
    logic [7:0] mq[$];
    int         mdrop = 0;
    int         mst   = 0;
    bit         mlastv = 1'b0;
    logic [7:0] mlast;
    bit         live = 1'b0;

    always @(posedge clk) begin
        logic [7:0] r;
        bit         acc, dp, pp;
        if (rst) begin
            mq.delete();
            mdrop  = 0;
            mst    = 0;
            mlastv = 1'b0;
        end else begin
            r   = {hif.ev_prod, hif.ev_cons, hif.ev_kind};
            pp  = (mq.size() != 0) && (mst != 2) && hif.rd_ready;
            acc = (mst == 0) && hif.ev_valid && (hif.ev_kind != 2'b00) && (hif.ev_prod != 3'd0);
            dp  = DEDUP && mlastv && (mlast == r);
            if (flush && mst != 2) begin
                mq.delete();
                mdrop  = 0;
                mlastv = 1'b0;
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc && !dp) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(r);
                        mlast  = r;
                        mlastv = 1'b1;
                    end else if (mdrop < 255) begin
                        mdrop++;
                    end
                end
            end
            case (mst)
                0:       mst = flush ? 2 : (freeze ? 1 : 0);
                1:       mst = flush ? 2 : (freeze ? 1 : 0);
                default: mst = freeze ? 1 : 0;
            endcase
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        logic [63:0] em;
        bit          ev;
        if (live) begin
            em = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (i < mq.size()) em[8*i +: 8] = mq[i];
            end
            ev = (mq.size() != 0) && (mst != 2);
            check("m_count", 64'(count), 64'(mq.size()));
            check("m_drop_cnt", 64'(drop_cnt), 64'(mdrop));
            check("m_state", 64'(state), 64'(mst));
            check("m_rd_valid", 64'(hif.rd_valid), 64'(ev));
            check("m_hazard_mem", hazard_mem, em);
            if (ev) check("m_rd_data", 64'(hif.rd_data), 64'(mq[0]));
        end
    end

    task automatic step(input logic v, input logic [2:0] p, input logic [2:0] c, input logic [1:0] k,
                        input logic rdy, input logic fz, input logic fl);
        hif.ev_valid = v;
        hif.ev_prod  = p;
        hif.ev_cons  = c;
        hif.ev_kind  = k;
        hif.rd_ready = rdy;
        freeze       = fz;
        flush        = fl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 3'd0, 2'd0, 0, 0, 0);
    endtask

    task automatic push_gen(input int i, input logic rdy);
        step(1, 3'((i % 7) + 1), 3'(i % 8), 2'(1 + (i % 3)), rdy, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        check("rst_rd_valid", 64'(hif.rd_valid), 64'd0);
        check("rst_rd_data", 64'(hif.rd_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_hazard_mem", hazard_mem, 64'd0);
        rst = 1'b0;

        step(1, 3'd3, 3'd5, 2'b01, 0, 0, 0);
        check("first_rd_valid", 64'(hif.rd_valid), 64'd1);
        check("first_rd_data", 64'(hif.rd_data), 64'h75);
        check("first_count", 64'(count), 64'd1);

        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 10; i++) push_gen(i, 0);
        check("fill_count", 64'(count), 64'd8);
        check("fill_drop_cnt", 64'(drop_cnt), 64'd2);
        check("fill_slot0", 64'(hazard_mem[7:0]), 64'h21);
        check("fill_slot7", 64'(hazard_mem[63:56]), 64'h3E);

        step(1, 3'd4, 3'd4, 2'b10, 1, 0, 0);
        check("pushpop_count", 64'(count), 64'd8);
        check("pushpop_drop_cnt", 64'(drop_cnt), 64'd2);
        check("pushpop_head", 64'(hif.rd_data), 64'h46);
        check("pushpop_slot7", 64'(hazard_mem[63:56]), 64'h92);

        step(0, 3'd0, 3'd0, 2'd0, 0, 1, 0);
        check("freeze_state", 64'(state), 64'd1);
        step(1, 3'd2, 3'd2, 2'b01, 0, 1, 0);
        step(1, 3'd3, 3'd3, 2'b10, 0, 1, 0);
        step(1, 3'd4, 3'd4, 2'b11, 0, 1, 0);
        check("frozen_count", 64'(count), 64'd8);
        check("frozen_drop_cnt", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) step(0, 3'd0, 3'd0, 2'd0, 1, 1, 0);
        check("drained_count", 64'(count), 64'd0);
        check("drained_rd_valid", 64'(hif.rd_valid), 64'd0);
        check("drained_state", 64'(state), 64'd1);
        idle(1);
        check("thaw_state", 64'(state), 64'd0);
        step(1, 3'd5, 3'd2, 2'b11, 0, 0, 0);
        check("resume_count", 64'(count), 64'd1);
        check("resume_rd_data", 64'(hif.rd_data), 64'hAB);

        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 12; i++) push_gen(i, 0);
        for (int i = 0; i < 3; i++) step(0, 3'd0, 3'd0, 2'd0, 1, 0, 0);
        check("preflush_count", 64'(count), 64'd5);
        check("preflush_drop_cnt", 64'(drop_cnt), 64'd4);
        step(1, 3'd7, 3'd7, 2'b11, 0, 0, 1);
        check("flush_state", 64'(state), 64'd2);
        check("flush_rd_valid", 64'(hif.rd_valid), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_drop_cnt", 64'(drop_cnt), 64'd0);
        step(1, 3'd7, 3'd7, 2'b10, 0, 0, 0);
        check("postflush_state", 64'(state), 64'd0);
        idle(1);
        check("flush_discard_count", 64'(count), 64'd0);

        for (int i = 0; i < 3; i++) step(1, 3'd6, 3'd6, 2'b11, 0, 0, 0);
        check("dedup_count", 64'(count), DEDUP ? 64'd1 : 64'd3);
        step(1, 3'd0, 3'd5, 2'b01, 0, 0, 0);
        step(1, 3'd0, 3'd6, 2'b11, 0, 0, 0);
        step(1, 3'd4, 3'd1, 2'b00, 0, 0, 0);
        check("r0_kind0_count", 64'(count), DEDUP ? 64'd1 : 64'd3);

        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 300; i++) push_gen(i, 0);
        check("sat_drop_cnt", 64'(drop_cnt), 64'd255);
        check("sat_count", 64'(count), 64'd8);

        rst = 1'b1;
        step(1, 3'd2, 3'd2, 2'b01, 1, 1, 1);
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
